// File: rtl/gpr_write_arbiter.sv
// Two-requester GPR write-port arbiter with starvation guard and a pending-write
// scoreboard used for source-register hazard detection.
module gpr_write_arbiter #(
   parameter int unsigned STARVE_LIM = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [4:0]  req0_addr,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [4:0]  req1_addr,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   input  logic        claim_valid,
   input  logic [4:0]  claim_addr,
   input  logic [4:0]  rs_a,
   input  logic [4:0]  rs_b,
   output logic        stall,
   output logic        RFWr,
   output logic [4:0]  A3,
   output logic [31:0] WD,
   output logic [31:0] pend
);

   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;
   localparam int unsigned NREG  = 32;
   localparam int unsigned CNT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
   localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

   logic [CNT_W-1:0] starve_q, starve_d;
   logic             rfwr_q, rfwr_d;
   logic [AW-1:0]    a3_q, a3_d;
   logic [DW-1:0]    wd_q, wd_d;
   logic [NREG-1:0]  pend_q, pend_d;

   logic             gnt0, gnt1, accept;
   logic [AW-1:0]    waddr;
   logic [DW-1:0]    wdata;

   // Fixed priority to req0, overridden once req1 has been refused STARVE_LIM times
   always_comb begin
      gnt1   = !reset && req1_valid && (!req0_valid || (starve_q == LIM));
      gnt0   = !reset && req0_valid && !gnt1;
      accept = gnt0 || gnt1;
      waddr  = gnt1 ? req1_addr : req0_addr;
      wdata  = gnt1 ? req1_data : req0_data;
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      starve_d = starve_q;
      rfwr_d   = 1'b0;
      a3_d     = a3_q;
      wd_d     = wd_q;
      pend_d   = pend_q;

      if (!req1_valid || gnt1) begin
         starve_d = '0;
      end else if (starve_q != LIM) begin
         starve_d = starve_q + CNT_W'(1);
      end

      // Writes to r0 are accepted but never reach the register file
      if (accept) begin
         rfwr_d        = (waddr != '0);
         a3_d          = waddr;
         wd_d          = wdata;
         pend_d[waddr] = 1'b0;
      end

      // Claim applied after the clear so a same-edge claim wins
      if (claim_valid && (claim_addr != '0)) begin
         pend_d[claim_addr] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
         rfwr_q   <= 1'b0;
         a3_q     <= '0;
         wd_q     <= '0;
         pend_q   <= '0;
      end else begin
         starve_q <= starve_d;
         rfwr_q   <= rfwr_d;
         a3_q     <= a3_d;
         wd_q     <= wd_d;
         pend_q   <= pend_d;
      end
   end

   assign stall = pend_q[rs_a] | pend_q[rs_b];
   assign RFWr  = rfwr_q;
   assign A3    = a3_q;
   assign WD    = wd_q;
   assign pend  = pend_q;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Directed table-driven bench for gpr_write_arbiter plus hand-written reset
// and starvation sequences.
module tb_gpr_write_arbiter;

   logic        clk;
   logic        reset;
   logic        req0_valid;
   logic [4:0]  req0_addr;
   logic [31:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [4:0]  req1_addr;
   logic [31:0] req1_data;
   logic        req1_ready;
   logic        claim_valid;
   logic [4:0]  claim_addr;
   logic [4:0]  rs_a;
   logic [4:0]  rs_b;
   logic        stall;
   logic        RFWr;
   logic [4:0]  A3;
   logic [31:0] WD;
   logic [31:0] pend;

   gpr_write_arbiter #(.STARVE_LIM(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .claim_valid(claim_valid),
      .claim_addr (claim_addr),
      .rs_a       (rs_a),
      .rs_b       (rs_b),
      .stall      (stall),
      .RFWr       (RFWr),
      .A3         (A3),
      .WD         (WD),
      .pend       (pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        r0v;
      logic [4:0]  r0a;
      logic [31:0] r0d;
      logic        r1v;
      logic [4:0]  r1a;
      logic [31:0] r1d;
      logic        cv;
      logic [4:0]  ca;
      logic [4:0]  rsa;
      logic [4:0]  rsb;
      logic        e_r0rdy;
      logic        e_r1rdy;
      logic        e_stall;
      logic        e_rfwr;
      logic        chk_aw;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
      logic [31:0] e_pend;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs [NVEC];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic drive_idle();
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      claim_valid = 1'b0; claim_addr = '0; rs_a = '0; rs_b = '0;
   endtask

   initial begin
      //        r0v r0a  r0d           r1v r1a  r1d           cv ca    rsa   rsb   r0r r1r st  rfw aw a3    wd            pend
      vecs[0]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1234, 32'h0};
      vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0};
      vecs[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h80};
      vecs[3]  = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'hCAFE, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h33, 32'h80};
      vecs[4]  = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'hCAFE, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h33, 32'h80};
      vecs[5]  = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'hCAFE, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h44, 32'h80};
      vecs[6]  = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'hCAFE, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 32'hCAFE, 32'h0};
      vecs[7]  = '{1'b1, 5'd4, 32'h55, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h55, 32'h0};
      vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99, 32'h200};
      vecs[9]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h200};
      vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hAB, 1'b0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'hAB, 32'h0};

      reset = 1'b1;
      drive_idle();
      #1;
      check("rst_rfwr", 32'(RFWr), 32'h0);
      check("rst_a3", 32'(A3), 32'h0);
      check("rst_wd", WD, 32'h0);
      check("rst_pend", pend, 32'h0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("rst_r0rdy", 32'(req0_ready), 32'h0);
      check("rst_r1rdy", 32'(req1_ready), 32'h0);
      drive_idle();
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         req0_valid = vecs[i].r0v; req0_addr = vecs[i].r0a; req0_data = vecs[i].r0d;
         req1_valid = vecs[i].r1v; req1_addr = vecs[i].r1a; req1_data = vecs[i].r1d;
         claim_valid = vecs[i].cv; claim_addr = vecs[i].ca;
         rs_a = vecs[i].rsa; rs_b = vecs[i].rsb;
         #1;
         check($sformatf("v%0d_r0rdy", i), 32'(req0_ready), 32'(vecs[i].e_r0rdy));
         check($sformatf("v%0d_r1rdy", i), 32'(req1_ready), 32'(vecs[i].e_r1rdy));
         check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_rfwr", i), 32'(RFWr), 32'(vecs[i].e_rfwr));
         check($sformatf("v%0d_pend", i), pend, vecs[i].e_pend);
         if (vecs[i].chk_aw) begin
            check($sformatf("v%0d_a3", i), 32'(A3), 32'(vecs[i].e_a3));
            check($sformatf("v%0d_wd", i), WD, vecs[i].e_wd);
         end
      end

      // Build up starvation count and a pending write, then reset between edges
      drive_idle();
      req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
      claim_valid = 1'b1; claim_addr = 5'd12;
      @(posedge clk);
      #1;
      check("pre_rfwr", 32'(RFWr), 32'h1);
      check("pre_pend", pend, 32'h1000);
      claim_valid = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rfwr", 32'(RFWr), 32'h0);
      check("mid_a3", 32'(A3), 32'h0);
      check("mid_wd", WD, 32'h0);
      check("mid_pend", pend, 32'h0);
      check("mid_r0rdy", 32'(req0_ready), 32'h0);
      @(posedge clk);
      #1;
      check("hold_rfwr", 32'(RFWr), 32'h0);
      drive_idle();
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rfwr", 32'(RFWr), 32'h0);

      // Starvation counter restarts from zero after reset: 3 req0 grants, then req1
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("starve%0d_r0rdy", c), 32'(req0_ready), (c == 3) ? 32'h0 : 32'h1);
         check($sformatf("starve%0d_r1rdy", c), 32'(req1_ready), (c == 3) ? 32'h1 : 32'h0);
         @(posedge clk);
         #1;
         check($sformatf("starve%0d_a3", c), 32'(A3), (c == 3) ? 32'd2 : 32'd1);
      end
      drive_idle();
      @(posedge clk);
      #1;
      check("final_idle_rfwr", 32'(RFWr), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gpr_write_arbiter.md
GPR_WRITE_ARBITER -- requirements
Module: gpr_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 3, meaning consecutive cycles req1 may be refused before it is forced a grant.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req0_addr/req0_data, input, 1/5/32, the pipeline write-back write request.
REQ-005 SHALL have port req0_ready, output, 1, combinational grant to requester 0.
REQ-006 SHALL have ports req1_valid/req1_addr/req1_data, input, 1/5/32, the multi-cycle unit write request.
REQ-007 SHALL have port req1_ready, output, 1, combinational grant to requester 1.
REQ-008 SHALL have ports claim_valid/claim_addr, input, 1/5, reserving a destination register for a future write.
REQ-009 SHALL have ports rs_a/rs_b, input, 5 each, source register numbers under hazard check.
REQ-010 SHALL have port stall, output, 1, high when rs_a or rs_b names a pending register.
REQ-011 SHALL have ports RFWr/A3/WD, output, 1/5/32, registered GPR write port.
REQ-012 SHALL have port pend, output, 32, the scoreboard vector.

Function
REQ-013 SHALL accept a request at an edge when its valid and ready are both high.
REQ-014 SHALL assert at most one ready per cycle, and SHALL keep ready low for any requester whose valid is low.
REQ-015 SHALL grant requester 0 when both are valid, unless starve_cnt equals STARVE_LIM, in which case requester 1 is granted.
REQ-016 SHALL increment starve_cnt, saturating at STARVE_LIM, on each edge where req1_valid is high and req1 is not granted.
REQ-017 SHALL clear starve_cnt on any edge where req1 is granted or req1_valid is low.
REQ-018 SHALL, on the edge accepting a request, load A3 and WD from the granted requester and set RFWr to 1, giving one cycle of latency.
REQ-019 SHALL set RFWr to 0 on an edge that accepts no request, and SHALL hold A3 and WD at their previous values.
REQ-020 SHALL accept a request addressed to register 0, assert its ready, and leave RFWr at 0 for it.
REQ-021 SHALL set pend[claim_addr] on an edge where claim_valid is high and claim_addr is not 0.
REQ-022 SHALL clear pend[addr] on the edge accepting a write to addr.
REQ-023 SHALL let the set win when a claim and an accepted write target the same register on the same edge.
REQ-024 SHALL hold pend[0] at 0 at all times.
REQ-025 SHALL compute stall combinationally as pend[rs_a] OR pend[rs_b].
REQ-026 SHALL ignore an accepted write to a non-pending register for scoreboard purposes, and SHALL still perform the write.

Reset
REQ-027 SHALL, while reset is high, immediately force RFWr=0, A3=0, WD=0, pend=0 and starve_cnt=0, independent of clk.
REQ-028 SHALL hold req0_ready and req1_ready at 0 while reset is high.
REQ-029 SHALL drop any request in flight when reset is asserted mid-operation, with no write emitted after reset release.

Verification
REQ-030 SHALL cover: reset asserted between edges -> RFWr, A3, WD and pend read 0 before the next clk edge.
REQ-031 SHALL cover: req0 alone, addr 5, data 0x1234 -> req0_ready=1 that cycle; next cycle RFWr=1, A3=5, WD=0x1234; following idle cycle RFWr=0.
REQ-032 SHALL cover: both requesters valid continuously, STARVE_LIM=3 -> grants req0 for 3 cycles, req1 on the 4th, then req0 again.
REQ-033 SHALL cover: claim addr 7, then rs_a=7 -> stall=1 until the edge accepting req1 addr 7; stall=0 the cycle after that edge.
REQ-034 SHALL cover: claim addr 9 on the same edge as an accepted write to 9 -> pend[9]=1 afterwards.
REQ-035 SHALL cover: req0 addr 0 with data 0xFFFFFFFF -> req0_ready=1; next cycle RFWr=0; pend[0]=0 after claim_addr=0.
